vga_mode_sequencer: RTL and testbench

- Sequences display-mode changes for the VGA pattern datapath.
- Takes single-cycle press pulses from the push-button debouncers and maintains a target mode index.
- Applies a new mode only at a frame boundary, through a req/ready handshake with the pattern generator.
- Forces blanking for the duration of the switch, so the monitor never sees a half-frame mix of two modes.

---
 rtl/vga_mode_pkg.sv | 42 ++++
 rtl/vga_mode_timeout_ctr.sv | 37 +++
 rtl/vga_mode_sequencer.sv | 168 ++++++++++++++++
 tb/tb_vga_mode_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_mode_pkg.sv
// ---------------------------------------------------------------------------
// vga_mode_pkg
// Shared types and helpers for the VGA mode sequencer.
//   state_t     : sequencer FSM states
//   mode_width  : width of a mode index for a given mode count
//   mode_step   : wrapped +1 / -1 step of a mode index
// ---------------------------------------------------------------------------
package vga_mode_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        SWITCH,
        SETTLE
    } state_t;

    // A single bit is still needed when only two modes exist.
    function automatic int unsigned mode_width(input int unsigned num_modes);
        if (num_modes <= 2) begin
            return 1;
        end
        return int'($clog2(num_modes));
    endfunction

    // dir = 1 steps forward, dir = 0 steps back; both wrap inside 0..num_modes-1
    // so a non-power-of-two mode count never yields an out-of-range index.
    function automatic int unsigned mode_step(input int unsigned index,
                                              input logic        dir,
                                              input int unsigned num_modes);
        if (dir) begin
            if (index >= num_modes - 1) begin
                return 0;
            end
            return index + 1;
        end
        if (index == 0 || index >= num_modes) begin
            return num_modes - 1;
        end
        return index - 1;
    endfunction

endpackage

// File: rtl/vga_mode_timeout_ctr.sv
// ---------------------------------------------------------------------------
// vga_mode_timeout_ctr
// Saturating up-counter with synchronous clear and count enable.
//   clk       : system clock
//   n_reset   : asynchronous active-low reset
//   clear     : return count to zero (wins over enable)
//   enable    : advance by one while below MAX_COUNT
//   terminal  : count has reached MAX_COUNT
// ---------------------------------------------------------------------------
module vga_mode_timeout_ctr #(
    parameter int unsigned MAX_COUNT = 1023
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned W = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);

    logic [W-1:0] count;

    // Count holds at MAX_COUNT until cleared.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !terminal) begin
            count <= count + W'(1);
        end
    end

    assign terminal = (count == W'(MAX_COUNT));

endmodule

// File: rtl/vga_mode_sequencer.sv
// ---------------------------------------------------------------------------
// vga_mode_sequencer
// Tracks a target display mode from button pulses and applies it to the
// pattern generator only at a frame boundary, via a req/ready handshake,
// blanking the output for exactly one frame around the change.
//   clk, n_reset  : clock, asynchronous active-low reset
//   next_pulse    : advance target mode (one-cycle pulse)
//   prev_pulse    : step target mode back (one-cycle pulse)
//   frame_start   : start of vertical blank (one-cycle pulse)
//   gen_ready     : generator has loaded mode_sel
//   mode_sel      : applied mode
//   mode_pending  : target differs from applied mode, or switch in flight
//   switch_req    : load request to the generator
//   blank_force   : datapath must output black
//   err_timeout   : sticky, gen_ready did not arrive in time
// Optional build macro VGA_MODE_AUTOCYCLE_EN: advance the mode automatically
// every HOLD_FRAMES idle frames.
// ---------------------------------------------------------------------------
module vga_mode_sequencer
    import vga_mode_pkg::*;
#(
    parameter  int unsigned NUM_MODES      = 4,
    parameter  int unsigned RESET_MODE     = 0,
    parameter  int unsigned TIMEOUT_CYCLES = 1023,
    parameter  int unsigned HOLD_FRAMES    = 60,
    localparam int unsigned MODE_W         = mode_width(NUM_MODES)
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              next_pulse,
    input  logic              prev_pulse,
    input  logic              frame_start,
    input  logic              gen_ready,
    output logic [MODE_W-1:0] mode_sel,
    output logic              mode_pending,
    output logic              switch_req,
    output logic              blank_force,
    output logic              err_timeout
);

    if (NUM_MODES < 2 || NUM_MODES > 16 || RESET_MODE >= NUM_MODES ||
        TIMEOUT_CYCLES < 1 || HOLD_FRAMES < 1) begin : g_param_check
        $error("vga_mode_sequencer: illegal parameter set");
    end

    state_t            state, state_next;
    logic [MODE_W-1:0] target, target_next, mode_sel_next;
    logic              switch_req_next, blank_force_next, err_timeout_next;
    logic              pending_next;
    logic              step_up, step_dn;
    logic              auto_pulse;
    logic              timeout_hit;

    // Handshake watchdog: runs only while a switch request is outstanding.
    vga_mode_timeout_ctr #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk      (clk),
        .n_reset  (n_reset),
        .clear    (state != SWITCH),
        .enable   (state == SWITCH),
        .terminal (timeout_hit)
    );

`ifdef VGA_MODE_AUTOCYCLE_EN
    logic hold_en, hold_clear, hold_done;

    // Counts quiet idle frames; the frame that finds it at HOLD_FRAMES-1
    // acts as a next press. Any user press restarts the hold period.
    assign hold_en    = frame_start && (state == IDLE) && !mode_pending;
    assign auto_pulse = hold_en && hold_done;
    assign hold_clear = auto_pulse || next_pulse || prev_pulse || (state != IDLE);

    vga_mode_timeout_ctr #(
        .MAX_COUNT (HOLD_FRAMES - 1)
    ) u_hold_ctr (
        .clk      (clk),
        .n_reset  (n_reset),
        .clear    (hold_clear),
        .enable   (hold_en),
        .terminal (hold_done)
    );
`else
    assign auto_pulse = 1'b0;
`endif

    // Next-state logic. The target is edited in every state; the applied
    // mode only moves on the frame_start seen in WAIT_FRAME.
    always_comb begin
        step_up          = next_pulse || auto_pulse;
        step_dn          = prev_pulse;
        target_next      = target;
        state_next       = state;
        mode_sel_next    = mode_sel;
        switch_req_next  = switch_req;
        blank_force_next = blank_force;
        err_timeout_next = err_timeout;

        if (step_up && !step_dn) begin
            target_next = MODE_W'(mode_step(32'(target), 1'b1, NUM_MODES));
        end else if (step_dn && !step_up) begin
            target_next = MODE_W'(mode_step(32'(target), 1'b0, NUM_MODES));
        end

        case (state)
            IDLE: begin
                if (target_next != mode_sel) begin
                    state_next = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                // Backing out to the applied mode cancels without a switch.
                if (target_next == mode_sel) begin
                    state_next = IDLE;
                end else if (frame_start) begin
                    mode_sel_next    = target_next;
                    switch_req_next  = 1'b1;
                    blank_force_next = 1'b1;
                    state_next       = SWITCH;
                end
            end
            SWITCH: begin
                // Ready wins over a coincident timeout.
                if (gen_ready) begin
                    switch_req_next = 1'b0;
                    state_next      = SETTLE;
                end else if (timeout_hit) begin
                    switch_req_next  = 1'b0;
                    err_timeout_next = 1'b1;
                    state_next       = SETTLE;
                end
            end
            SETTLE: begin
                if (frame_start) begin
                    blank_force_next = 1'b0;
                    state_next       = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        pending_next = (target_next != mode_sel_next) || (state_next != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            target       <= MODE_W'(RESET_MODE);
            mode_sel     <= MODE_W'(RESET_MODE);
            mode_pending <= 1'b0;
            switch_req   <= 1'b0;
            blank_force  <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_next;
            target       <= target_next;
            mode_sel     <= mode_sel_next;
            mode_pending <= pending_next;
            switch_req   <= switch_req_next;
            blank_force  <= blank_force_next;
            err_timeout  <= err_timeout_next;
        end
    end

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vga_mode_sequencer
// Directed bench for vga_mode_sequencer: a 4-mode instance carries the main
// sequence, a 3-mode instance (reset mode 2) shares the stimulus to show the
// non-power-of-two wrap.
// ---------------------------------------------------------------------------
module tb_vga_mode_sequencer;

    localparam int unsigned TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       next_pulse = 1'b0;
    logic       prev_pulse = 1'b0;
    logic       frame_start = 1'b0;
    logic       gen_ready = 1'b0;

    logic [1:0] mode_sel;
    logic       mode_pending, switch_req, blank_force, err_timeout;
    logic [1:0] mode_sel3;
    logic       mode_pending3, switch_req3, blank_force3, err_timeout3;

    int total = 0;
    int bad   = 0;

    vga_mode_sequencer #(
        .NUM_MODES      (4),
        .RESET_MODE     (0),
        .TIMEOUT_CYCLES (TIMEOUT),
        .HOLD_FRAMES    (4)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .next_pulse   (next_pulse),
        .prev_pulse   (prev_pulse),
        .frame_start  (frame_start),
        .gen_ready    (gen_ready),
        .mode_sel     (mode_sel),
        .mode_pending (mode_pending),
        .switch_req   (switch_req),
        .blank_force  (blank_force),
        .err_timeout  (err_timeout)
    );

    vga_mode_sequencer #(
        .NUM_MODES      (3),
        .RESET_MODE     (2),
        .TIMEOUT_CYCLES (TIMEOUT),
        .HOLD_FRAMES    (4)
    ) dut3 (
        .clk          (clk),
        .n_reset      (n_reset),
        .next_pulse   (next_pulse),
        .prev_pulse   (prev_pulse),
        .frame_start  (frame_start),
        .gen_ready    (gen_ready),
        .mode_sel     (mode_sel3),
        .mode_pending (mode_pending3),
        .switch_req   (switch_req3),
        .blank_force  (blank_force3),
        .err_timeout  (err_timeout3)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let the edge capture them, then release.
    task automatic applyStimulus(input logic nx, input logic pv,
                                 input logic fs, input logic gr);
        next_pulse  = nx;
        prev_pulse  = pv;
        frame_start = fs;
        gen_ready   = gr;
        @(posedge clk);
        #1;
        next_pulse  = 1'b0;
        prev_pulse  = 1'b0;
        frame_start = 1'b0;
        gen_ready   = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Finish a switch already in SWITCH: ready, then the settling frame.
    task automatic finishSwitch();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_mode",    32'(mode_sel), 0);
        checkOutput("rst_pending", 32'(mode_pending), 0);
        checkOutput("rst_req",     32'(switch_req), 0);
        checkOutput("rst_blank",   32'(blank_force), 0);
        checkOutput("rst_err",     32'(err_timeout), 0);
        checkOutput("rst_mode3",   32'(mode_sel3), 2);
        n_reset = 1'b1;
        idleCycles(2);
        checkOutput("idle_pending", 32'(mode_pending), 0);

        // Basic switch 0 -> 1
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t1_pending", 32'(mode_pending), 1);
        checkOutput("t1_mode_hold", 32'(mode_sel), 0);
        idleCycles(2);
        checkOutput("t1_mode_wait", 32'(mode_sel), 0);
        checkOutput("t1_req_wait",  32'(switch_req), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_mode_new", 32'(mode_sel), 1);
        checkOutput("t1_req_on",   32'(switch_req), 1);
        checkOutput("t1_blank_on", 32'(blank_force), 1);
        checkOutput("wrap3_next",  32'(mode_sel3), 0);
        idleCycles(2);
        checkOutput("t1_req_held", 32'(switch_req), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("t1_req_off",    32'(switch_req), 0);
        checkOutput("t1_blank_held", 32'(blank_force), 1);
        idleCycles(3);
        checkOutput("t1_blank_settle", 32'(blank_force), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t1_blank_off", 32'(blank_force), 0);
        checkOutput("t1_idle",      32'(mode_pending), 0);

        // Two presses before the frame: 1 -> 3 in one switch
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("x2_mode_hold", 32'(mode_sel), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("x2_mode", 32'(mode_sel), 3);
        finishSwitch();
        checkOutput("x2_idle", 32'(mode_pending), 0);

        // Wrap forward 3 -> 0
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("wrap_next", 32'(mode_sel), 0);
        finishSwitch();

        // Wrap back 0 -> 3
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("wrap_prev", 32'(mode_sel), 3);
        finishSwitch();
        checkOutput("wrap_prev_idle", 32'(mode_pending), 0);

        // Simultaneous presses in IDLE do nothing
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("both_idle", 32'(mode_pending), 0);

        // WAIT_FRAME: both keep waiting, then back out to IDLE
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("both_wait", 32'(mode_pending), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("cancel_pending", 32'(mode_pending), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("cancel_req",  32'(switch_req), 0);
        checkOutput("cancel_mode", 32'(mode_sel), 3);

        // Timeout: 3 -> 0 with gen_ready held low
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idleCycles(TIMEOUT - 1);
        checkOutput("to_req_early", 32'(switch_req), 1);
        checkOutput("to_err_early", 32'(err_timeout), 0);
        idleCycles(4);
        checkOutput("to_req_off", 32'(switch_req), 0);
        checkOutput("to_err",     32'(err_timeout), 1);
        checkOutput("to_mode",    32'(mode_sel), 0);
        checkOutput("to_blank",   32'(blank_force), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idleCycles(3);
        checkOutput("to_err_sticky", 32'(err_timeout), 1);
        checkOutput("to_blank_off",  32'(blank_force), 0);

        // Press during SWITCH is held off until after SETTLE: 0 -> 1 -> 2
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_mode", 32'(mode_sel), 1);
        checkOutput("mid_req",  32'(switch_req), 1);
        finishSwitch();
        checkOutput("mid_mode_after", 32'(mode_sel), 1);
        checkOutput("mid_pending",    32'(mode_pending), 1);
        checkOutput("mid_blank_off",  32'(blank_force), 0);
        idleCycles(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mid_second_mode", 32'(mode_sel), 2);
        checkOutput("mid_second_req",  32'(switch_req), 1);
        finishSwitch();

        // Reset asserted in SWITCH
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("rs_req_before", 32'(switch_req), 1);
        n_reset = 1'b0;
        #2;
        checkOutput("rs_mode",    32'(mode_sel), 0);
        checkOutput("rs_req",     32'(switch_req), 0);
        checkOutput("rs_blank",   32'(blank_force), 0);
        checkOutput("rs_err",     32'(err_timeout), 0);
        checkOutput("rs_pending", 32'(mode_pending), 0);
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        idleCycles(2);
        checkOutput("rs_after_pending", 32'(mode_pending), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
